instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer in front of a synchronous-read instruction memory. It owns the fetch PC and issues one word read per cycle. Returned instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the buffer, discard the in-flight read and restart fetch; a misaligned redirect target raises a sticky fault.

Parameters:
ADDR_BITS, 10, byte-address width decoded by instruction memory; mem_addr upper bits are driven but not checked.
RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.
DEPTH, 4, instruction FIFO entries; power of two, >=2; >=3 required for 1 instr/cycle sustained.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
mem_req  out  1  read strobe to instruction memory
mem_addr  out  XLEN  byte address of read, always [1:0]=0
mem_rdata  in  INSTR_LEN  read data, valid in the cycle after the mem_req cycle
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  XLEN  redirect target
instr_valid  out  1  FIFO head valid to decode
instr_ready  in  1  decode accepts head
instr  out  INSTR_LEN  head instruction
instr_pc  out  XLEN  PC of head instruction
fetch_fault  out  1  misaligned redirect target seen; fetch halted

Behaviour:
- Reset (rst=1 at edge): fetch_pc<=RESET_PC, FIFO empty, in-flight flag cleared, fetch_fault<=0. While rst=1 and the cycle after: mem_req=0, instr_valid=0. rst has priority over everything.
- State: fetch_pc, inflight (0/1) + inflight_pc, FIFO (count 0..DEPTH, rd/wr pointers wrapping mod DEPTH), fetch_fault.
- Issue: mem_req=1, mem_addr=fetch_pc when !fetch_fault && !redirect_valid && (count+inflight)<DEPTH. Pops in the same cycle give no credit. On issue: fetch_pc<=fetch_pc+4, mod 2^XLEN, wraps silently; inflight<=1, inflight_pc<=fetch_pc. Otherwise inflight<=0.
- Response: if inflight=1 in a cycle with no redirect, push {mem_rdata, inflight_pc} at the end of that cycle. The credit rule guarantees no overflow; push to a full FIFO is an assertion failure.
- Output: instr_valid=(count!=0). instr/instr_pc=head. Handshake when instr_valid&&instr_ready pops the head. Simultaneous push+pop leaves count unchanged. Pop on empty cannot occur.
- Latency: rst low at edge E0 -> mem_req at RESET_PC in cycle E0..E1 -> data pushed at E2 -> instr_valid from E2. Sustained 1 instr/cycle with instr_ready=1 and DEPTH>=3.
- Redirect (redirect_valid=1 in cycle C): any handshake in C completes (the head is consumed). At the end of C: FIFO flushed (count<=0), inflight response discarded (inflight<=0, mem_rdata ignored), no mem_req in C.
  - If redirect_pc[1:0]==0: fetch_pc<=redirect_pc, fetch_fault<=0, first mem_req at redirect_pc in C+1.
  - Else: fetch_fault<=1, fetch_pc<=redirect_pc; no mem_req until a later aligned redirect clears the fault.
- Back-to-back redirects: the last one wins; each flushes.
- instr_ready low: FIFO fills to DEPTH, then mem_req stays 0, mem_addr holds the next fetch_pc. Stall never drops or duplicates an instruction.
- Memory-side data is never inspected; instruction contents do not affect sequencing.

Test Plan:
- Reset release, instr_ready=1, memory word[i]=i: mem_addr 0,4,8,...; first instr_valid 2 cycles after release; then instr=0,1,2,... with instr_pc=0,4,8 every cycle, no gaps.
- instr_ready=0 for 10 cycles after reset: exactly DEPTH=4 reads issued (0..0xC), mem_req then 0. Raising ready drains 0..3 in order, then 0x10 follows with no loss or duplication.
- Redirect to 0x100 while FIFO holds 2 entries and a read is in flight: no mem_req in the redirect cycle, mem_req at 0x100 next cycle. Old entries and the in-flight word never appear; next instr_pc=0x100.
- Redirect coincident with a handshake at head pc 0x8: pc 0x8 is consumed exactly once, and the following instr_pc is the redirect target.
- Redirect to 0x102: fetch_fault=1, mem_req stays 0, instr_valid 0. A later redirect to 0x200 clears the fault, and fetch resumes at 0x200.
- rst asserted mid-stream with a full FIFO: next cycle instr_valid=0, mem_req=0, fetch_fault=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
// Fetch sequencer for a synchronous-read instruction memory. It owns the fetch
// PC and issues at most one word read per cycle. Returned words are queued with
// their PC in a small FIFO that decode drains over a valid/ready handshake.
// A redirect flushes the queue, drops the read in flight and restarts fetch.
// A misaligned redirect target halts fetch behind a sticky fault until an
// aligned redirect arrives.
module instr_fetch_ctrl #(
  parameter int unsigned     ADDR_BITS = 10,
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INSTR_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic [XLEN-1:0]      mem_addr,
  input  logic [INSTR_LEN-1:0] mem_rdata,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] instr,
  output logic [XLEN-1:0]      instr_pc,
  output logic                 fetch_fault
);

  // Reject configurations the pointer arithmetic and alignment logic cannot
  // support. The memory decodes only ADDR_BITS of mem_addr; the rest are
  // driven anyway.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instr_fetch_ctrl: RESET_PC must be 4-byte aligned");
  end
  if (ADDR_BITS < 3 || ADDR_BITS > XLEN) begin : g_bad_addr_bits
    $error("instr_fetch_ctrl: ADDR_BITS must lie between 3 and XLEN");
  end

  // Pointers wrap naturally because DEPTH is a power of two. The count needs
  // one extra bit so that it can hold DEPTH itself.
  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam int unsigned       CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Sequencing state
  logic [XLEN-1:0]      r_fetch_pc;
  logic                 r_inflight;
  logic [XLEN-1:0]      r_inflight_pc;
  logic                 r_fault;
  logic                 r_rst_q;

  // Instruction FIFO
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [INSTR_LEN-1:0] r_instr_q [DEPTH];
  logic [XLEN-1:0]      r_pc_q    [DEPTH];

  logic [CNT_W:0]       w_occupancy;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_valid;
  logic                 w_pop;

  // Credit is everything already queued plus the read still in flight. A pop
  // in the current cycle does not free a slot until the next cycle, which
  // keeps the issue decision off the decode ready path.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};

  // No read in a reset cycle, in the first cycle after reset, while faulted,
  // or in a redirect cycle (its address would be stale).
  assign w_issue = !rst && !r_rst_q && !r_fault && !redirect_valid
                   && (w_occupancy < DEPTH_OCC);

  // A returning word is kept unless a redirect in the same cycle discards it.
  assign w_push  = r_inflight && !redirect_valid;

  assign w_valid = !rst && (r_count != '0);
  assign w_pop   = w_valid && instr_ready;

  assign mem_req     = w_issue;
  assign mem_addr    = {r_fetch_pc[XLEN-1:2], 2'b00};
  assign instr_valid = w_valid;
  assign instr       = r_instr_q[r_rd_ptr];
  assign instr_pc    = r_pc_q[r_rd_ptr];
  assign fetch_fault = r_fault;

  // Remember that the previous edge was a reset edge so that issue holds off
  // for one cycle after reset.
  // NOTE: sequential state is written with <= so every flop samples values
  // from before the edge; a blocking = here would leak new values into later
  // statements and make simulation depend on statement order.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  // Fetch PC, in-flight tracking, fault flag and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fault       <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Flush everything; a handshake in this cycle has already been
      // accepted by decode, so dropping the head is correct.
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_fault    <= (redirect_pc[1:0] != 2'b00);
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + XLEN'(4);
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: capture the returning word together with its PC.
  // NOTE: the storage array has no reset; the count and pointers already
  // define which entries are meaningful, and resetting a memory array costs
  // a reset mux on every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_instr_q[r_wr_ptr] <= mem_rdata;
      r_pc_q[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl
// Directed scenarios plus a randomized run for instr_fetch_ctrl. Expected
// values come from a stream-level reference: decode must see PCs start,
// start+4, ... restarting at every redirect, each exactly once, and reads may
// be outstanding up to DEPTH (issued minus consumed).
module tb_instr_fetch_ctrl;

  localparam int          XLEN      = 32;
  localparam int          INSTR_LEN = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] salt = '0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .ADDR_BITS(10), .XLEN(XLEN), .INSTR_LEN(INSTR_LEN),
    .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  // Synchronous-read memory; garbage when not read so stale use is visible.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= word(mem_addr);
    else         mem_rdata <= $urandom();
  end

  // ---------------- reference model ----------------
  logic [31:0] m_issue_pc = RESET_PC;
  logic [31:0] m_exp_pc   = RESET_PC;
  int          m_out      = 0;
  bit          m_prev_issue = 1'b0;
  bit          m_fault    = 1'b0;
  bit          m_after_rst = 1'b0;

  bit          e_req, e_valid, e_fault;
  logic [31:0] e_addr, e_pc, e_instr;

  bit          p_rst, p_rdv, p_rdy;
  logic [31:0] p_rpc;
  bit          have_prev = 1'b0;

  task automatic model_advance();
    if (p_rst) begin
      m_issue_pc = RESET_PC; m_exp_pc = RESET_PC; m_out = 0;
      m_prev_issue = 1'b0; m_fault = 1'b0; m_after_rst = 1'b1;
    end else if (p_rdv) begin
      m_issue_pc = p_rpc; m_exp_pc = p_rpc; m_out = 0;
      m_prev_issue = 1'b0; m_fault = (p_rpc[1:0] != 2'b00); m_after_rst = 1'b0;
    end else begin
      if (e_valid && p_rdy) begin m_exp_pc += 4; m_out--; end
      if (e_req) begin m_issue_pc += 4; m_out++; end
      m_prev_issue = e_req;
      m_after_rst  = 1'b0;
    end
  endtask

  task automatic model_expect();
    e_req   = !rst && !m_after_rst && !m_fault && !redirect_valid && (m_out < DEPTH);
    e_addr  = m_issue_pc;
    e_valid = !rst && ((m_out - int'(m_prev_issue)) > 0);
    e_pc    = m_exp_pc;
    e_instr = word(m_exp_pc);
    e_fault = m_fault;
  endtask

  // Drive one cycle's inputs at the falling edge and sample outputs 1 ns later.
  task automatic cycle(input bit r, input bit rdv, input logic [31:0] rpc, input bit rdy);
    if (have_prev) model_advance();
    @(negedge clk);
    rst = r; redirect_valid = rdv; redirect_pc = rpc; instr_ready = rdy;
    #1;
    model_expect();
    p_rst = r; p_rdv = rdv; p_rpc = rpc; p_rdy = rdy; have_prev = 1'b1;
  endtask

  task automatic do_reset(input bit rdy);
    cycle(1, 0, 0, rdy);
    cycle(1, 0, 0, rdy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    salt = '0;
    do_reset(1);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    cycle(0, 0, 0, 1);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_after_mem_req: got %b want 0", mem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_after_valid: got %b want 0", instr_valid); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
  endtask

  task automatic test_stream();
    logic [31:0] x;
    salt = '0;
    do_reset(1);
    for (int k = 0; k < 14; k++) begin
      cycle(0, 0, 0, 1);
      n_checks++;
      if (mem_req !== (k >= 1)) begin n_fail++; $display("FAIL stream_mem_req k=%0d: got %b want %b", k, mem_req, k >= 1); end
      if (k >= 1) begin
        x = 32'((k - 1) * 4);
        n_checks++; if (mem_addr !== x) begin n_fail++; $display("FAIL stream_mem_addr k=%0d: got %h want %h", k, mem_addr, x); end
      end
      n_checks++;
      if (instr_valid !== (k >= 3)) begin n_fail++; $display("FAIL stream_valid k=%0d: got %b want %b", k, instr_valid, k >= 3); end
      if (k >= 3) begin
        x = 32'((k - 3) * 4);
        n_checks++; if (instr_pc !== x) begin n_fail++; $display("FAIL stream_pc k=%0d: got %h want %h", k, instr_pc, x); end
        x = 32'(k - 3);
        n_checks++; if (instr !== x) begin n_fail++; $display("FAIL stream_instr k=%0d: got %h want %h", k, instr, x); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] addrs[$];
    logic [31:0] got[$];
    logic [31:0] x;
    salt = $urandom();
    do_reset(0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0);
      if (mem_req === 1'b1) addrs.push_back(mem_addr);
    end
    n_checks++; if (addrs.size() != DEPTH) begin n_fail++; $display("FAIL stall_num_reads: got %0d want %0d", addrs.size(), DEPTH); end
    for (int i = 0; i < addrs.size() && i < DEPTH; i++) begin
      x = 32'(i * 4);
      n_checks++; if (addrs[i] !== x) begin n_fail++; $display("FAIL stall_read_addr %0d: got %h want %h", i, addrs[i], x); end
    end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_mem_req_held: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_mem_addr_held: got %h want 00000010", mem_addr); end
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 0, 1);
      if (instr_valid === 1'b1) begin
        got.push_back(instr_pc);
        n_checks++; if (instr !== word(instr_pc)) begin n_fail++; $display("FAIL stall_drain_data pc=%h: got %h want %h", instr_pc, instr, word(instr_pc)); end
      end
    end
    n_checks++; if (got.size() < 8) begin n_fail++; $display("FAIL stall_drain_count: got %0d want >=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      x = 32'(i * 4);
      n_checks++; if (got[i] !== x) begin n_fail++; $display("FAIL stall_drain_order %0d: got %h want %h", i, got[i], x); end
    end
  endtask

  task automatic test_redirect_flush();
    logic [31:0] got[$];
    salt = $urandom();
    do_reset(0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h100, 0);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req_in_redirect: got %b want 0", mem_req); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_precond_valid: got %b want 1", instr_valid); end
    cycle(0, 0, 0, 1);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_req_after: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL flush_addr_after: got %h want 00000100", mem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after: got %b want 0", instr_valid); end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 1);
      if (instr_valid === 1'b1) got.push_back(instr_pc);
    end
    n_checks++; if (got.size() < 2) begin n_fail++; $display("FAIL flush_no_output: got %0d entries want >=2", got.size()); end
    else begin
      n_checks++; if (got[0] !== 32'h100) begin n_fail++; $display("FAIL flush_first_pc: got %h want 00000100", got[0]); end
      n_checks++; if (got[1] !== 32'h104) begin n_fail++; $display("FAIL flush_second_pc: got %h want 00000104", got[1]); end
    end
  endtask

  task automatic test_redirect_handshake();
    int seen8;
    logic [31:0] got[$];
    salt = $urandom();
    do_reset(1);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h40, 1);
    seen8 = (instr_valid === 1'b1 && instr_pc === 32'h8) ? 1 : 0;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin n_fail++; $display("FAIL hs_head: got valid=%b pc=%h want valid=1 pc=00000008", instr_valid, instr_pc); end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 1);
      if (instr_valid === 1'b1) begin
        got.push_back(instr_pc);
        if (instr_pc === 32'h8) seen8++;
      end
    end
    n_checks++; if (seen8 != 1) begin n_fail++; $display("FAIL hs_consumed_once: got %0d want 1", seen8); end
    n_checks++; if (got.size() == 0 || got[0] !== 32'h40) begin n_fail++; $display("FAIL hs_next_pc: got %h want 00000040", (got.size() == 0) ? 32'hx : got[0]); end
  endtask

  task automatic test_fault();
    logic [31:0] got[$];
    salt = $urandom();
    do_reset(1);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h102, 1);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fault_req_in_redirect: got %b want 0", mem_req); end
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 1);
      n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_flag k=%0d: got %b want 1", k, fetch_fault); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fault_mem_req k=%0d: got %b want 0", k, mem_req); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid k=%0d: got %b want 0", k, instr_valid); end
    end
    cycle(0, 1, 32'h200, 1);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fault_clear_cycle_req: got %b want 0", mem_req); end
    cycle(0, 0, 0, 1);
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b want 0", fetch_fault); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL fault_resume: got req=%b addr=%h want req=1 addr=00000200", mem_req, mem_addr); end
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 1);
      if (instr_valid === 1'b1) got.push_back(instr_pc);
    end
    n_checks++; if (got.size() == 0 || got[0] !== 32'h200) begin n_fail++; $display("FAIL fault_first_pc: got %h want 00000200", (got.size() == 0) ? 32'hx : got[0]); end
  endtask

  task automatic test_reset_midstream();
    salt = $urandom();
    do_reset(0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);
    n_checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_precond_full: got valid=%b req=%b want 1/0", instr_valid, mem_req); end
    cycle(1, 0, 0, 0);
    n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_during_rst: got valid=%b req=%b want 0/0", instr_valid, mem_req); end
    cycle(0, 0, 0, 1);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid: got %b want 0", instr_valid); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_after_req: got %b want 0", mem_req); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mid_after_fault: got %b want 0", fetch_fault); end
    cycle(0, 0, 0, 1);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RESET_PC); end
    cycle(0, 1, 32'h13, 1);
    cycle(0, 0, 0, 1);
    n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mid_fault_set: got %b want 1", fetch_fault); end
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mid_fault_reset: got %b want 0", fetch_fault); end
  endtask

  task automatic test_random();
    bit r, rdv, rdy;
    logic [31:0] rpc;
    int sel;
    salt = $urandom();
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 99);
      rdv = (sel < 4);
      rpc = {20'h0, 10'($urandom()), 2'b00};
      if (sel == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 9) < 7);
      cycle(r, rdv, rpc, rdy);
      n_checks++; if (mem_req !== e_req) begin n_fail++; $display("FAIL rand_mem_req cyc %0d: got %b want %b", i, mem_req, e_req); end
      if (e_req) begin
        n_checks++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rand_mem_addr cyc %0d: got %h want %h", i, mem_addr, e_addr); end
      end
      n_checks++; if (instr_valid !== e_valid) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", i, instr_valid, e_valid); end
      if (e_valid) begin
        n_checks++; if (instr_pc !== e_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d: got %h want %h", i, instr_pc, e_pc); end
        n_checks++; if (instr !== e_instr) begin n_fail++; $display("FAIL rand_instr cyc %0d: got %h want %h", i, instr, e_instr); end
      end
      n_checks++; if (fetch_fault !== e_fault) begin n_fail++; $display("FAIL rand_fault cyc %0d: got %b want %b", i, fetch_fault, e_fault); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_handshake();
    test_fault();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
